// File: rtl/uart_pkg.sv
// Shared types and frame constants for the buffered UART port.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_core.sv
// Bit-level 8N1 serialiser: loads a byte on a baud tick and shifts one bit per tick.
module uart_tx_core
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 abort,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ack,
  output logic                 line,
  output logic                 idle
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_cnt;
  logic                 line_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    ack        = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else if (tick) begin
      case (state)
        IDLE:  if (valid) begin state_next = START; ack = 1'b1; end
        START: state_next = DATA;
        DATA:  if (bit_cnt == LAST_BIT) state_next = STOP;
        STOP:  if (valid) begin state_next = START; ack = 1'b1; end
               else state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
      line_q  <= 1'b1;
    end else if (abort) begin
      line_q <= 1'b1;
    end else if (tick) begin
      if (ack) begin
        shift  <= data;
        line_q <= 1'b0;
      end else begin
        case (state)
          START: begin
            line_q  <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
              line_q <= 1'b1;
            end else begin
              line_q  <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: line_q <= 1'b1;
        endcase
      end
    end
  end

  // Dropping out of transmit mode releases the line in the same cycle.
  assign line = line_q | abort;
  assign idle = (state == IDLE);

endmodule

// File: rtl/uart_port.sv
// Buffered 8N1 UART: oversampled RX into an indexed buffer, indexed TX buffer drained on baud ticks.
module uart_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 187,
  parameter int RX_DEPTH     = 64,
  parameter int TX_DEPTH     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_clk,
  input  logic        uart_port_DI,
  input  logic        rx_clear,
  input  logic [15:0] read_ptr,
  output logic [7:0]  uart_DO,
  output logic        read_valid,
  input  logic        tx_clear,
  input  logic [15:0] send_ptr,
  input  logic [7:0]  tx_DI,
  output logic        uart_port_DO,
  output logic        send_done
);

  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [RAW:0]  RX_FULL   = RX_DEPTH[RAW:0];
  localparam logic [TAW:0]  TX_FULL   = TX_DEPTH[TAW:0];

  logic [1:0] di_sync, bclk_sync;
  logic       di_prev, bclk_prev, di, baud_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      di_sync   <= 2'b11;
      di_prev   <= 1'b1;
      bclk_sync <= 2'b00;
      bclk_prev <= 1'b0;
    end else begin
      di_sync   <= {di_sync[0], uart_port_DI};
      di_prev   <= di_sync[1];
      bclk_sync <= {bclk_sync[0], uart_clk};
      bclk_prev <= bclk_sync[1];
    end
  end

  assign di        = di_sync[1];
  assign baud_tick = bclk_sync[1] & ~bclk_prev;

  uart_state_t          rx_state, rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bits;
  logic [DATA_BITS-1:0] rx_shift;
  logic [RAW:0]         rx_count;
  logic                 rx_sample, rx_write;
  logic [DATA_BITS-1:0] rx_buf [RX_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next   = rx_state;
    rx_sample = 1'b0;
    rx_write  = 1'b0;
    case (rx_state)
      IDLE:  if (di_prev && !di) rx_next = START;
      START: if (rx_cnt == HALF_LAST) begin
               rx_sample = 1'b1;
               rx_next   = di ? IDLE : DATA;
             end
      DATA:  if (rx_cnt == BIT_LAST) begin
               rx_sample = 1'b1;
               if (rx_bits == BW'(DATA_BITS - 1)) rx_next = STOP;
             end
      STOP:  if (rx_cnt == BIT_LAST) begin
               rx_sample = 1'b1;
               rx_write  = di && (rx_count < RX_FULL);
               rx_next   = IDLE;
             end
      default: rx_next = IDLE;
    endcase
    if (rx_clear) begin
      rx_next  = IDLE;
      rx_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_count <= '0;
    end else begin
      rx_cnt <= (rx_state == IDLE || rx_sample) ? '0 : rx_cnt + 1'b1;
      if (rx_state == START) rx_bits <= '0;
      if (rx_state == DATA && rx_sample) begin
        rx_shift <= {di, rx_shift[DATA_BITS-1:1]};
        rx_bits  <= rx_bits + 1'b1;
      end
      if (rx_clear)      rx_count <= '0;
      else if (rx_write) rx_count <= rx_count + 1'b1;
    end
  end

  // NOTE: buffer storage is deliberately not reset; rx_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (rx_write) rx_buf[rx_count[RAW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_DO    <= '0;
      read_valid <= 1'b0;
    end else begin
      uart_DO    <= rx_buf[read_ptr[RAW-1:0]];
      read_valid <= read_ptr < 16'(rx_count);
    end
  end

  logic [DATA_BITS-1:0] tx_buf [TX_DEPTH];
  logic                 tx_clear_q, tx_rise, tx_valid, tx_ack, tx_idle;
  logic [TAW:0]         tx_count, tx_idx;

  always_ff @(posedge clk) begin
    if (!tx_clear) tx_buf[send_ptr[TAW-1:0]] <= tx_DI;
  end

  assign tx_rise  = tx_clear & ~tx_clear_q;
  assign tx_valid = tx_clear & ~tx_rise & (tx_idx < tx_count);

  // tx_clear_q resets high so a port held in transmit mode through reset does not re-latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_clear_q <= 1'b1;
      tx_count   <= '0;
      tx_idx     <= '0;
      send_done  <= 1'b1;
    end else begin
      tx_clear_q <= tx_clear;
      if (tx_rise) begin
        tx_count <= (send_ptr > 16'(TX_DEPTH)) ? TX_FULL : send_ptr[TAW:0];
        tx_idx   <= '0;
      end else if (tx_ack) begin
        tx_idx <= tx_idx + 1'b1;
      end
      if (!tx_clear)    send_done <= 1'b0;
      else if (tx_rise) send_done <= (send_ptr == 16'd0);
      else              send_done <= (tx_idx >= tx_count) && tx_idle;
    end
  end

  uart_tx_core u_tx_core (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (baud_tick),
    .abort (~tx_clear),
    .valid (tx_valid),
    .data  (tx_buf[tx_idx[TAW-1:0]]),
    .ack   (tx_ack),
    .line  (uart_port_DO),
    .idle  (tx_idle)
  );

endmodule

// File: tb/tb_uart_port.sv
// Randomised self-checking bench for uart_port against a queue-based frame model.
module tb_uart_port;
  import uart_pkg::*;

  localparam int CPB        = 16;
  localparam int RXD        = 8;
  localparam int TXD        = 8;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_clk;
  logic        uart_port_DI;
  logic        rx_clear;
  logic [15:0] read_ptr;
  logic [7:0]  uart_DO;
  logic        read_valid;
  logic        tx_clear;
  logic [15:0] send_ptr;
  logic [7:0]  tx_DI;
  logic        uart_port_DO;
  logic        send_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_rx[$];
  logic [7:0] tx_ref[$];

  uart_port #(.CLKS_PER_BIT(CPB), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_clk     (uart_clk),
    .uart_port_DI (uart_port_DI),
    .rx_clear     (rx_clear),
    .read_ptr     (read_ptr),
    .uart_DO      (uart_DO),
    .read_valid   (read_valid),
    .tx_clear     (tx_clear),
    .send_ptr     (send_ptr),
    .tx_DI        (tx_DI),
    .uart_port_DO (uart_port_DO),
    .send_done    (send_done)
  );

  always #5 clk = ~clk;

  initial begin
    uart_clk = 1'b0;
    #3;
    forever #(CPB * 5) uart_clk = ~uart_clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serial RX frame: start, 8 data LSB first, chosen stop level, then idle.
  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_port_DI = frame[i];
      repeat (CPB) @(negedge clk);
    end
    uart_port_DI = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (stop && model_rx.size() < RXD) model_rx.push_back(b);
  endtask

  task automatic rx_check_all(input string tag);
    for (int i = 0; i < RXD + 2; i++) begin
      read_ptr = 16'(i);
      @(negedge clk);
      check({tag, "_valid"}, 32'(read_valid), 32'(i < model_rx.size()));
      if (i < model_rx.size()) check({tag, "_data"}, 32'(uart_DO), 32'(model_rx[i]));
    end
    read_ptr = 16'hFFFF;
    @(negedge clk);
    check({tag, "_far_ptr"}, 32'(read_valid), 32'd0);
  endtask

  task automatic tx_load();
    tx_clear = 1'b0;
    for (int i = 0; i < tx_ref.size(); i++) begin
      send_ptr = 16'(i);
      tx_DI    = tx_ref[i];
      @(negedge clk);
    end
    check("tx_load_send_done", 32'(send_done), 32'd0);
  endtask

  task automatic tx_go(input int cnt);
    send_ptr = 16'(cnt);
    tx_clear = 1'b1;
    @(negedge clk);
  endtask

  // Samples the line mid-bit from the first start bit; consecutive frames must abut exactly.
  task automatic tx_expect(input int nframes, input string tag);
    int t;
    logic [FRAME_BITS-1:0] obs;
    t = 0;
    while (uart_port_DO === 1'b1 && t < 4 * CPB) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_start_seen"}, 32'(uart_port_DO), 32'd0);
    if (uart_port_DO !== 1'b0) return;
    check({tag, "_busy"}, 32'(send_done), 32'd0);
    repeat (CPB / 2) @(negedge clk);
    for (int f = 0; f < nframes; f++) begin
      for (int b = 0; b < FRAME_BITS; b++) begin
        obs[b] = uart_port_DO;
        repeat (CPB) @(negedge clk);
      end
      check({tag, "_frame"}, 32'(obs), 32'({1'b1, tx_ref[f], 1'b0}));
    end
    check({tag, "_done"}, 32'(send_done), 32'd1);
    check({tag, "_line_idle"}, 32'(uart_port_DO), 32'd1);
  endtask

  task automatic check_line_idle(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (uart_port_DO !== 1'b1) lows++;
      @(negedge clk);
    end
    check(tag, 32'(lows), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    uart_port_DI = 1'b1;
    rx_clear     = 1'b0;
    read_ptr     = 16'd0;
    tx_clear     = 1'b1;
    send_ptr     = 16'd0;
    tx_DI        = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_tx_line", 32'(uart_port_DO), 32'd1);
    check("reset_send_done", 32'(send_done), 32'd1);
    check("reset_read_valid", 32'(read_valid), 32'd0);
    check("reset_uart_do", 32'(uart_DO), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    rx_send(8'h41, 1'b1);
    rx_check_all("rx_0x41");

    for (int i = 0; i < 4; i++) rx_send(8'($urandom), (i != 2));
    rx_check_all("rx_random_framing");

    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
    model_rx.delete();
    rx_check_all("rx_clear");

    for (int i = 0; i < RXD + 1; i++) rx_send(8'($urandom), 1'b1);
    rx_check_all("rx_overflow");
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
    model_rx.delete();

    tx_ref = '{8'h41, 8'h42};
    tx_load();
    tx_go(1);
    tx_expect(1, "tx_single");
    check_line_idle("tx_single_no_extra", 3 * CPB);

    tx_load();
    tx_go(2);
    tx_expect(2, "tx_burst2");

    tx_ref.delete();
    for (int i = 0; i < 3 + int'($urandom_range(0, 2)); i++) tx_ref.push_back(8'($urandom));
    tx_load();
    tx_go(tx_ref.size());
    tx_expect(tx_ref.size(), "tx_burst_rand");

    tx_load();
    tx_go(0);
    @(negedge clk);
    check("tx_zero_done", 32'(send_done), 32'd1);
    check_line_idle("tx_zero_line", 3 * CPB);

    tx_ref.delete();
    for (int i = 0; i < TXD; i++) tx_ref.push_back(8'($urandom));
    tx_load();
    tx_go(100);
    tx_expect(TXD, "tx_clamp");
    check_line_idle("tx_clamp_no_extra", 3 * CPB);

    tx_load();
    tx_go(2);
    repeat (3 * CPB) @(negedge clk);
    tx_clear = 1'b0;
    #1;
    check("tx_abort_line", 32'(uart_port_DO), 32'd1);
    @(negedge clk);
    check("tx_abort_done", 32'(send_done), 32'd0);

    tx_go(2);
    uart_port_DI = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst_n        = 1'b0;
    uart_port_DI = 1'b1;
    #1;
    check("midrst_tx_line", 32'(uart_port_DO), 32'd1);
    check("midrst_send_done", 32'(send_done), 32'd1);
    check("midrst_read_valid", 32'(read_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_rx.delete();
    repeat (4) @(negedge clk);
    rx_check_all("midrst_rx_empty");
    rx_send(8'($urandom), 1'b1);
    rx_check_all("midrst_rx_after");
    check_line_idle("midrst_tx_quiet", 3 * CPB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
